// File: rtl/z80_io_pkg.sv
// Shared types and constants for the Z80 I/O bridge: FSM encoding and port-window width.
package z80_io_pkg;

  localparam int unsigned PORT_AW = 2;
  localparam int unsigned BUS_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_STRETCH = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // True when the address falls inside the port window starting at base.
  function automatic logic in_window(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] base);
    return a[BUS_W-1:PORT_AW] == base[BUS_W-1:PORT_AW];
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/z80_io_bridge.sv
// Z80 I/O bus front end: synchronizes the strobes, decodes a 4-port window and
// turns each accepted I/O cycle into one clk-wide peripheral strobe plus WAIT_n stretch.
module z80_io_bridge
  import z80_io_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               z_iorq_n,
  input  logic               z_m1_n,
  input  logic               z_rd_n,
  input  logic               z_wr_n,
  input  logic [BUS_W-1:0]   z_addr,
  input  logic [BUS_W-1:0]   z_data_in,
  output logic [BUS_W-1:0]   z_data_out,
  output logic               z_data_oe,
  output logic               z_wait_n,
  input  logic [BUS_W-1:0]   periph_data,
  output logic               cs_n,
  output logic               rd_n,
  output logic               wr_n,
  output logic [PORT_AW-1:0] addr,
  output logic [BUS_W-1:0]   data_out
);

  localparam int unsigned CNT_W = 4;

  logic iorq_s, m1_s, rd_s, wr_s;

  // iorq chain resets to "busy" so a cycle in flight at reset release is never taken.
  sync2 #(.RST_VAL(1'b0)) u_sync_iorq (.clk(clk), .reset_n(reset_n), .d(z_iorq_n), .q(iorq_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_m1   (.clk(clk), .reset_n(reset_n), .d(z_m1_n),   .q(m1_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_rd   (.clk(clk), .reset_n(reset_n), .d(z_rd_n),   .q(rd_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_wr   (.clk(clk), .reset_n(reset_n), .d(z_wr_n),   .q(wr_s));

  state_t             state_q, state_d;
  logic               iorq_q;
  logic               armed_q, armed_d;
  logic               is_read_q, is_read_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               rd_n_q, rd_n_d;
  logic               wr_n_q, wr_n_d;
  logic               wait_n_q, wait_n_d;
  logic               oe_q, oe_d;
  logic [PORT_AW-1:0] addr_q, addr_d;
  logic [BUS_W-1:0]   data_out_q, data_out_d;
  logic [BUS_W-1:0]   zdo_q, zdo_d;
  logic               start_c;

  assign start_c = armed_q && !iorq_s && iorq_q && m1_s && (rd_s ^ wr_s)
                   && in_window(z_addr, BASE_ADDR);

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | iorq_s;
    is_read_d  = is_read_q;
    cnt_d      = cnt_q;
    cs_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    wait_n_d   = wait_n_q;
    oe_d       = oe_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    zdo_d      = zdo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          addr_d     = z_addr[PORT_AW-1:0];
          data_out_d = z_data_in;
          is_read_d  = !rd_s;
          wait_n_d   = 1'b0;
          cs_n_d     = 1'b0;
          rd_n_d     = rd_s;
          wr_n_d     = wr_s;
          state_d    = ST_STROBE;
        end
      end
      ST_STROBE: begin
        cnt_d = CNT_W'(WAIT_CYCLES);
        if (is_read_q) begin
          zdo_d = periph_data;
          oe_d  = 1'b1;
        end
        state_d = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (cnt_q == '0) begin
          wait_n_d = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (iorq_s) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      iorq_q     <= 1'b0;
      armed_q    <= 1'b0;
      is_read_q  <= 1'b0;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      wait_n_q   <= 1'b1;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      data_out_q <= '0;
      zdo_q      <= '0;
    end else begin
      state_q    <= state_d;
      iorq_q     <= iorq_s;
      armed_q    <= armed_d;
      is_read_q  <= is_read_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      wait_n_q   <= wait_n_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      zdo_q      <= zdo_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign rd_n       = rd_n_q;
  assign wr_n       = wr_n_q;
  assign addr       = addr_q;
  assign data_out   = data_out_q;
  assign z_wait_n   = wait_n_q;
  assign z_data_oe  = oe_q;
  assign z_data_out = zdo_q;

endmodule

// File: tb/tb_z80_io_bridge.sv
// Directed bench for z80_io_bridge: instance a (base 0x00, 2 waits), instance b (base 0x40, 0 waits).
module tb_z80_io_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, z_iorq_n, z_m1_n, z_rd_n, z_wr_n;
  logic [7:0] z_addr, z_data_in, periph_data;

  logic [7:0] a_zdo, b_zdo, a_dout, b_dout;
  logic       a_oe, b_oe, a_wait, b_wait, a_cs, b_cs, a_rd, b_rd, a_wr, b_wr;
  logic [1:0] a_addr, b_addr;

  z80_io_bridge #(.BASE_ADDR(8'h00), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .z_iorq_n(z_iorq_n), .z_m1_n(z_m1_n),
    .z_rd_n(z_rd_n), .z_wr_n(z_wr_n), .z_addr(z_addr), .z_data_in(z_data_in),
    .z_data_out(a_zdo), .z_data_oe(a_oe), .z_wait_n(a_wait), .periph_data(periph_data),
    .cs_n(a_cs), .rd_n(a_rd), .wr_n(a_wr), .addr(a_addr), .data_out(a_dout));

  z80_io_bridge #(.BASE_ADDR(8'h40), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .z_iorq_n(z_iorq_n), .z_m1_n(z_m1_n),
    .z_rd_n(z_rd_n), .z_wr_n(z_wr_n), .z_addr(z_addr), .z_data_in(z_data_in),
    .z_data_out(b_zdo), .z_data_oe(b_oe), .z_wait_n(b_wait), .periph_data(periph_data),
    .cs_n(b_cs), .rd_n(b_rd), .wr_n(b_wr), .addr(b_addr), .data_out(b_dout));

  int n_assert = 0;
  int n_fail   = 0;

  bit sel_b;
  int cs_cnt, cs_first, wr_cnt, rd_cnt, wait_cnt, wait_first, oe_cnt, oe_first, other_cs, other_wait;
  logic [1:0] st_addr;
  logic [7:0] st_data, oe_data;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cs_cnt = 0; cs_first = -1; wr_cnt = 0; rd_cnt = 0; wait_cnt = 0; wait_first = -1;
    oe_cnt = 0; oe_first = -1; other_cs = 0; other_wait = 0;
    st_addr = '0; st_data = '0; oe_data = '0;
  endtask

  // Accumulate the selected instance's outputs for one post-edge sample.
  task automatic sample(input int idx);
    logic cs, rd, wr, wt, oe, ocs, owt;
    logic [1:0] ad;
    logic [7:0] dq, zd;
    if (sel_b) begin
      cs = b_cs; rd = b_rd; wr = b_wr; wt = b_wait; oe = b_oe; ad = b_addr; dq = b_dout; zd = b_zdo;
      ocs = a_cs; owt = a_wait;
    end else begin
      cs = a_cs; rd = a_rd; wr = a_wr; wt = a_wait; oe = a_oe; ad = a_addr; dq = a_dout; zd = a_zdo;
      ocs = b_cs; owt = b_wait;
    end
    if (!cs) begin
      cs_cnt++;
      if (cs_first < 0) cs_first = idx;
      st_addr = ad;
      st_data = dq;
    end
    if (!wr) wr_cnt++;
    if (!rd) rd_cnt++;
    if (!wt) begin
      wait_cnt++;
      if (wait_first < 0) wait_first = idx;
    end
    if (oe) begin
      oe_cnt++;
      if (oe_first < 0) begin
        oe_first = idx;
        oe_data  = zd;
      end
    end
    if (!ocs) other_cs++;
    if (!owt) other_wait++;
  endtask

  task automatic observe(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample(base + i);
    end
  endtask

  // One Z80 I/O cycle: IORQ_n low for low_n clk, then high for high_n clk.
  task automatic io_cycle(input bit is_wr, input bit m1, input logic [7:0] a,
                          input logic [7:0] d, input int low_n, input int high_n);
    clear_stats();
    z_addr = a; z_data_in = d; z_m1_n = m1;
    z_iorq_n = 1'b0; z_rd_n = is_wr; z_wr_n = !is_wr;
    observe(low_n, 0);
    z_iorq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1; z_m1_n = 1'b1;
    observe(high_n, low_n);
  endtask

  initial begin
    sel_b = 1'b0;
    reset_n = 1'b0; z_iorq_n = 1'b1; z_m1_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;
    z_addr = 8'h00; z_data_in = 8'h00; periph_data = 8'h00;
    clear_stats();
    #12;
    check("rst_cs_n", int'(a_cs), 1);
    check("rst_rd_n", int'(a_rd), 1);
    check("rst_wr_n", int'(a_wr), 1);
    check("rst_wait_n", int'(a_wait), 1);
    check("rst_oe", int'(a_oe), 0);
    check("rst_data_out", int'(a_dout), 0);
    check("rst_addr", int'(a_addr), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    observe(4, 0);

    // Write 0xA5 to port 0
    io_cycle(1'b1, 1'b1, 8'h00, 8'hA5, 12, 4);
    check("wr_cs_count", cs_cnt, 1);
    check("wr_cs_latency", cs_first, 2);
    check("wr_wr_count", wr_cnt, 1);
    check("wr_rd_count", rd_cnt, 0);
    check("wr_addr", int'(st_addr), 0);
    check("wr_data", int'(st_data), 8'hA5);
    check("wr_wait_len", wait_cnt, 4);
    check("wr_wait_start", wait_first, 2);
    check("wr_oe_count", oe_cnt, 0);
    check("wr_other_cs", other_cs, 0);
    check("wr_data_hold", int'(a_dout), 8'hA5);

    // Read port 3 returning 0x3C
    periph_data = 8'h3C;
    io_cycle(1'b0, 1'b1, 8'h03, 8'h00, 12, 4);
    check("rd_cs_count", cs_cnt, 1);
    check("rd_cs_latency", cs_first, 2);
    check("rd_rd_count", rd_cnt, 1);
    check("rd_wr_count", wr_cnt, 0);
    check("rd_addr", int'(st_addr), 3);
    check("rd_oe_start", oe_first, 3);
    check("rd_oe_data", int'(oe_data), 8'h3C);
    check("rd_oe_len", oe_cnt, 11);
    check("rd_wait_len", wait_cnt, 4);
    check("rd_oe_off", int'(a_oe), 0);

    // Out-of-window port and interrupt acknowledge are ignored
    io_cycle(1'b1, 1'b1, 8'h10, 8'h55, 8, 4);
    check("oow_cs_count", cs_cnt, 0);
    check("oow_wait_len", wait_cnt, 0);
    check("oow_other_cs", other_cs, 0);
    io_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8, 4);
    check("inta_cs_count", cs_cnt, 0);
    check("inta_wait_len", wait_cnt, 0);
    check("inta_oe_count", oe_cnt, 0);

    // Reset mid-STRETCH with IORQ_n held low
    clear_stats();
    z_addr = 8'h01; z_data_in = 8'h99; z_iorq_n = 1'b0; z_wr_n = 1'b0;
    observe(5, 0);
    check("rst4_pre_wait", int'(a_wait), 0);
    reset_n = 1'b0;
    #1;
    check("rst4_cs_n", int'(a_cs), 1);
    check("rst4_wait_n", int'(a_wait), 1);
    check("rst4_data_out", int'(a_dout), 0);
    check("rst4_addr", int'(a_addr), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_stats();
    observe(6, 0);
    z_iorq_n = 1'b1; z_wr_n = 1'b1;
    observe(3, 6);
    check("rst4_no_strobe", cs_cnt, 0);
    check("rst4_no_wait", wait_cnt, 0);
    io_cycle(1'b1, 1'b1, 8'h02, 8'h77, 12, 4);
    check("rst4_new_cs", cs_cnt, 1);
    check("rst4_new_latency", cs_first, 2);
    check("rst4_new_addr", int'(st_addr), 2);
    check("rst4_new_data", int'(st_data), 8'h77);
    check("rst4_new_wait", wait_cnt, 4);

    // Back-to-back writes on the zero-wait instance
    sel_b = 1'b1;
    io_cycle(1'b1, 1'b1, 8'h40, 8'h01, 6, 2);
    check("b2b1_cs_count", cs_cnt, 1);
    check("b2b1_latency", cs_first, 2);
    check("b2b1_data", int'(st_data), 8'h01);
    check("b2b1_wait_len", wait_cnt, 2);
    check("b2b1_other_cs", other_cs, 0);
    io_cycle(1'b1, 1'b1, 8'h41, 8'h02, 6, 4);
    check("b2b2_cs_count", cs_cnt, 1);
    check("b2b2_latency", cs_first, 2);
    check("b2b2_addr", int'(st_addr), 1);
    check("b2b2_data", int'(st_data), 8'h02);
    check("b2b2_wait_len", wait_cnt, 2);
    check("b2b2_wr_count", wr_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_io_bridge.md
Name: z80_io_bridge

Overview:
- Upstream bus front end for the simple I/O peripherals: sits between the raw asynchronous Z80 I/O bus pins and the peripheral chip-select interface (cs_n/rd_n/wr_n/addr/data).
- Synchronizes IORQ_n/M1_n/RD_n/WR_n into clk and decodes a 4-port window.
- Emits exactly one clk-wide peripheral strobe per Z80 I/O cycle and stretches the CPU cycle with WAIT_n.
- Returns read data to the CPU data bus with an output enable.

Parameters:
- BASE_ADDR, 8'h00, port window base; z_addr[7:2] is compared with BASE_ADDR[7:2].
- WAIT_CYCLES, 2, extra clk cycles wait_n stays low after the strobe (0..15, 4-bit counter).

Ports:
- clk  in  1  system clock; must be at least 4x the Z80 clock.
- reset_n  in  1  asynchronous, active-low reset.
- z_iorq_n  in  1  raw Z80 IORQ_n (asynchronous).
- z_m1_n  in  1  raw Z80 M1_n; low together with IORQ_n means interrupt acknowledge, which is ignored.
- z_rd_n  in  1  raw Z80 RD_n.
- z_wr_n  in  1  raw Z80 WR_n.
- z_addr  in  8  Z80 A[7:0]; stable while IORQ_n is low.
- z_data_in  in  8  Z80 data bus toward the bridge.
- z_data_out  out  8  read data toward the CPU.
- z_data_oe  out  1  drive enable for z_data_out.
- z_wait_n  out  1  Z80 WAIT_n.
- periph_data  in  8  read data from the selected peripheral.
- cs_n  out  1  peripheral chip select.
- rd_n  out  1  peripheral read strobe.
- wr_n  out  1  peripheral write strobe.
- addr  out  2  peripheral register index (latched z_addr[1:0]).
- data_out  out  8  latched write data to the peripheral.

Behaviour:
- Reset values: cs_n=1, rd_n=1, wr_n=1, addr=0, data_out=0, z_data_out=0, z_data_oe=0, z_wait_n=1, state=IDLE, armed=0.
- All outputs are registered; there is no combinational path from the raw z_* pins to any output.
- Synchronizers: two flops each on iorq_n, m1_n, rd_n, wr_n, plus one further flop on synchronized iorq (iorq_q) for edge detection.
  - iorq chain and iorq_q reset to 0 (busy). m1/rd/wr chains reset to 1.
- armed: set when synchronized iorq_n is 1; cleared only by reset. A cycle already in progress when reset releases never produces a strobe.
- Start condition (evaluated in IDLE): armed, falling edge (iorq_s=0, iorq_q=1), m1_s=1, exactly one of rd_s/wr_s low, and z_addr[7:2]==BASE_ADDR[7:2].
  - Any start condition failing leaves the FSM in IDLE; that cycle is ignored.
  - Covers both rd_s and wr_s low, neither low, and an interrupt-acknowledge cycle.
- FSM: IDLE -> STROBE -> STRETCH -> HOLD -> IDLE.
- IDLE: when the start condition holds, latch addr=z_addr[1:0], data_out=z_data_in, is_read=!rd_s; drive z_wait_n=0; next state STROBE.
- STROBE (exactly one clk): cs_n=0; rd_n=0 if is_read, else wr_n=0.
  - At the closing edge: deassert cs_n/rd_n/wr_n, load the wait counter with WAIT_CYCLES.
  - If is_read: z_data_out<=periph_data and z_data_oe<=1.
  - Next state STRETCH.
- STRETCH: counter decrements each clk. At 0, release z_wait_n=1 and go to HOLD. With WAIT_CYCLES=0 this takes one clk.
- HOLD: z_data_oe and z_data_out are held. When iorq_s returns to 1: z_data_oe<=0, go to IDLE.
- IORQ_n rising early:
  - If iorq_s returns high during STROBE or STRETCH, the sequence still completes without shortening the strobe.
  - HOLD then exits on the next clk.
- Latency: raw iorq_n first sampled low at edge E0; the fall is detected between E1 and E2.
  - cs_n/strobe are low from E2 to E3. The peripheral samples the strobe at E3.
  - z_wait_n is low from E2 until E3+WAIT_CYCLES+1.
- Write data and addr remain stable from E2 until the next accepted cycle.
- Asynchronous reset at any point: outputs go to reset values immediately and armed is cleared.

Decomposition:
- Shared package/header z80_io_pkg: FSM state encodings (IDLE=2'd0, STROBE=2'd1, STRETCH=2'd2, HOLD=2'd3) and the port-window width constant (2 address bits).
- One sub-module: sync2 (two-flop synchronizer, parameterised reset value), instantiated four times.

Test Plan:
1. Write port BASE+0 with 8'hA5 (iorq_n, wr_n low for 12 clk, m1_n=1) -> exactly one clk with cs_n=0, wr_n=0, rd_n=1, addr=0, data_out=A5; z_wait_n low for 1+WAIT_CYCLES+1 clk.
2. Read port BASE+3 with periph_data=8'h3C -> single rd_n pulse, addr=3; z_data_out=3C, z_data_oe=1 from E3 until 2-3 clk after iorq_n rises; never any wr_n pulse.
3. Access port 8'h10 with BASE_ADDR=0, and an interrupt-ack cycle (m1_n=0, iorq_n=0) -> no cs_n pulse, z_wait_n stays 1.
4. Assert reset_n low mid-STRETCH with iorq_n still low, release it with iorq_n still low -> outputs at reset values immediately, no strobe until iorq_n goes high and a new cycle starts; that new cycle strobes normally.
5. Back-to-back writes 8'h01 then 8'h02 separated by 2 clk of iorq_n high -> two distinct single-clk strobes with data_out 01 then 02; WAIT_CYCLES=0 gives a wait of 2 clk each.
